// File: rtl/ql_ap3_pkg.sv
// Shared definitions for AP3 RAM FIFO-mode controllers:
// port-mode encodings, read-controller states and width mapping.
package ql_ap3_pkg;

    localparam logic [1:0] RMODE_32 = 2'b00;
    localparam logic [1:0] RMODE_16 = 2'b01;
    localparam logic [1:0] RMODE_8  = 2'b10;

    localparam logic [1:0] WMODE_32 = RMODE_32;
    localparam logic [1:0] WMODE_16 = RMODE_16;
    localparam logic [1:0] WMODE_8  = RMODE_8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    function automatic logic [1:0] width_to_mode(input int width);
        logic [1:0] mode;
        case (width)
            8:       mode = RMODE_8;
            16:      mode = RMODE_16;
            default: mode = RMODE_32;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/ql_skid_buf2.sv
// Two-entry FIFO buffer with push/pop/clear and occupancy;
// the head entry is always presented on rdata.
module ql_skid_buf2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic [1:0]   occ
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   occ_q, occ_d;
    logic [1:0]   occ_p;
    logic         pop_ok;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        pop_ok = pop & (occ_q != 2'd0);
        occ_p  = occ_q - {1'b0, pop_ok};
        if (pop_ok) begin
            head_d = tail_q;
        end
        occ_d = occ_p;
        // a push lands in the first free slot after the pop has shifted
        if (push && (occ_p != 2'd2)) begin
            if (occ_p == 2'd0) begin
                head_d = wdata;
            end else begin
                tail_d = wdata;
            end
            occ_d = occ_p + 2'd1;
        end
        if (clr) begin
            occ_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign rdata = head_q;
    assign occ   = occ_q;

endmodule

// File: rtl/ql_fifo_rd_ctrl.sv
// AP3 RAM FIFO-mode read controller: REN credit logic, skid buffer, flush.
// Define QL_FIFO_RD_CNT_EN to enable the delivered-word counter rd_cnt.
module ql_fifo_rd_ctrl
    import ql_ap3_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           fifo_rdata,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    output logic [1:0]            fifo_rmode,
    output logic                  fifo_flush,
    input  logic                  flush_req,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [1:0]            occ,
    output logic [CNT_WIDTH-1:0]  rd_cnt
);

    rd_state_e state_q, state_d;
    logic      inflight_q, inflight_d;
    logic      pop;
    logic      push;
    logic      clr;
    logic [1:0] occ_w;
    logic [2:0] credit;

    assign fifo_rmode = width_to_mode(DATA_WIDTH);
    assign m_valid    = (occ_w != 2'd0);
    assign pop        = m_valid & m_ready;
    assign occ        = occ_w;
    assign credit     = {1'b0, occ_w} + {2'b0, inflight_q} - {2'b0, pop};

    always_comb begin
        state_d    = state_q;
        fifo_ren   = 1'b0;
        fifo_flush = 1'b0;
        busy       = 1'b0;
        clr        = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            RUN: begin
                fifo_ren = ~rst & ~fifo_empty & (credit < 3'd2);
                push     = inflight_q;
                // a word returning on the flush entry edge is discarded
                if (flush_req) begin
                    state_d = FLUSH;
                    clr     = 1'b1;
                    push    = 1'b0;
                end
            end
            FLUSH: begin
                fifo_flush = 1'b1;
                busy       = 1'b1;
                state_d    = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        inflight_d = fifo_ren;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    ql_skid_buf2 #(
        .W(DATA_WIDTH)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .wdata (fifo_rdata[DATA_WIDTH-1:0]),
        .pop   (pop),
        .rdata (m_data),
        .occ   (occ_w)
    );

`ifdef QL_FIFO_RD_CNT_EN
    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (clr) begin
            rd_cnt_d = '0;
        end else if (pop) begin
            rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
`else
    assign rd_cnt = '0;
`endif

endmodule
